// File: rtl/izigzag_dequant.sv
// izigzag_dequant: inverse zigzag plus dequantizer for one 8x8 block stream.
// Coefficients arrive in JPEG zigzag order. Each one is multiplied by its quant
// entry and saturated, then written at its raster position in a ping-pong block
// buffer. Complete blocks are streamed out in raster order.
module izigzag_dequant #(
    parameter int COEF_W = 12,
    parameter int Q_W    = 8,
    parameter int OUT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              q_load,
    input  logic [5:0]        q_addr,
    input  logic [Q_W-1:0]    q_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic              err
);

    // Full-precision product width, and the number of top product bits that
    // must all equal the sign bit for the value to fit in OUT_W.
    localparam int PROD_W = COEF_W + Q_W + 1;
    localparam int HI_W   = PROD_W - OUT_W + 1;

    // Zigzag index k -> raster index (row*8 + col), standard JPEG order.
    localparam logic [5:0] ZZ_RASTER [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_STREAM
    } rd_state_t;

    // Storage.
    logic [Q_W-1:0]   q_ram   [64];
    logic [OUT_W-1:0] blk_ram [128];   // index = {bank, raster}

    // Write-side control.
    logic [5:0] k;
    logic       wr_bank;
    logic [1:0] full;

    // Read-side control.
    rd_state_t  state, state_nxt;
    logic       rd_bank;
    logic [5:0] r;
    logic [5:0] rd_addr;

    // Stage 1: captured coefficient and its quant entry.
    logic              s1_valid;
    logic              s1_end;
    logic              s1_bank;
    logic [5:0]        s1_addr;
    logic [COEF_W-1:0] s1_data;
    logic [Q_W-1:0]    s1_q;

    // Stage 2: saturated product waiting for the bank write.
    logic             s2_valid;
    logic             s2_end;
    logic             s2_bank;
    logic [5:0]       s2_addr;
    logic [OUT_W-1:0] s2_data;

    logic                     in_hs;
    logic                     out_hs;
    logic                     blk_done;
    logic [1:0]               full_set;
    logic [1:0]               full_clr;
    logic signed [PROD_W-1:0] prod;
    logic [HI_W-1:0]          prod_hi;
    logic [OUT_W-1:0]         prod_sat;

    // Ready drops during reset so nothing is accepted into a discarded block.
    assign in_ready = rst_n && !full[wr_bank];
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;
    assign blk_done = (state == R_STREAM) && out_hs && (r == 6'd63);

    // Per-bank full set (last write lands) and clear (last read handshake).
    // NOTE: every signal driven in always_comb gets a default first, otherwise
    // a path that skips the assignment infers a latch.
    always_comb begin
        full_set = 2'b00;
        full_clr = 2'b00;
        if (s2_valid && s2_end) full_set[s2_bank] = 1'b1;
        if (blk_done)           full_clr[rd_bank] = 1'b1;
    end

    // Signed coefficient times zero-extended quant entry, saturated to OUT_W.
    always_comb begin
        prod    = $signed({{(PROD_W-COEF_W){s1_data[COEF_W-1]}}, s1_data})
                * $signed({{(PROD_W-Q_W){1'b0}}, s1_q});
        prod_hi = prod[PROD_W-1:OUT_W-1];
        if (prod_hi == '0 || prod_hi == '1)
            prod_sat = prod[OUT_W-1:0];
        else if (prod[PROD_W-1])
            prod_sat = {1'b1, {(OUT_W-1){1'b0}}};
        else
            prod_sat = {1'b0, {(OUT_W-1){1'b1}}};
    end

    // Quant table write port; contents persist across reset.
    // NOTE: memories are deliberately left out of reset so they map onto RAM;
    // their contents are meaningful only once written.
    always_ff @(posedge clk) begin
        if (q_load) q_ram[q_addr] <= q_data;
    end

    // Input handshake, zigzag counter, framing check and the two-stage pipeline.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k        <= '0;
            wr_bank  <= 1'b0;
            err      <= 1'b0;
            s1_valid <= 1'b0;
            s1_end   <= 1'b0;
            s1_bank  <= 1'b0;
            s1_addr  <= '0;
            s1_data  <= '0;
            s1_q     <= '0;
            s2_valid <= 1'b0;
            s2_end   <= 1'b0;
            s2_bank  <= 1'b0;
            s2_addr  <= '0;
            s2_data  <= '0;
        end else begin
            s1_valid <= in_hs;
            if (in_hs) begin
                s1_data <= in_data;
                s1_q    <= q_ram[ZZ_RASTER[k]];
                s1_addr <= ZZ_RASTER[k];
                s1_end  <= (k == 6'd63);
                s1_bank <= wr_bank;
                k       <= k + 6'd1;
                if (k == 6'd63) wr_bank <= ~wr_bank;
                // The block still completes by count; the flag only reports.
                if (in_last != (k == 6'd63)) err <= 1'b1;
            end
            s2_valid <= s1_valid;
            s2_end   <= s1_end;
            s2_bank  <= s1_bank;
            s2_addr  <= s1_addr;
            s2_data  <= prod_sat;
        end
    end

    // Block buffer write port.
    always_ff @(posedge clk) begin
        if (s2_valid) blk_ram[{s2_bank, s2_addr}] <= s2_data;
    end

    // Bank occupancy and read-bank pointer; set and clear hit different banks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full    <= 2'b00;
            rd_bank <= 1'b0;
        end else begin
            full <= (full | full_set) & ~full_clr;
            if (blk_done) rd_bank <= ~rd_bank;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= R_IDLE;
        else        state <= state_nxt;
    end

    // Read FSM next state. Idle also looks at the full flag being set this
    // cycle so the fetch overlaps the final bank write.
    always_comb begin
        state_nxt = state;
        unique case (state)
            R_IDLE:   if (full[rd_bank] || full_set[rd_bank]) state_nxt = R_FETCH;
            R_FETCH:  state_nxt = R_STREAM;
            R_STREAM: if (blk_done) state_nxt = R_IDLE;
            default:  state_nxt = R_IDLE;
        endcase
    end

    // Fetch reads raster 0; streaming prefetches r+1 on each handshake.
    assign rd_addr = (state == R_FETCH) ? 6'd0 : r + 6'd1;

    // Output register: loads only on fetch or handshake, so it holds on stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            r         <= '0;
        end else if (state == R_FETCH) begin
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            out_data  <= blk_ram[{rd_bank, rd_addr}];
            r         <= '0;
        end else if (state == R_STREAM && out_hs) begin
            if (r == 6'd63) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                r         <= '0;
            end else begin
                out_data <= blk_ram[{rd_bank, rd_addr}];
                out_last <= (r == 6'd62);
                r        <= r + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_izigzag_dequant.sv
// Directed bench for izigzag_dequant: identity, saturation, ping-pong
// backpressure, output stall, framing error and mid-block reset.
module tb_izigzag_dequant;

    localparam int COEF_W = 12;
    localparam int Q_W    = 8;
    localparam int OUT_W  = 16;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              q_load    = 1'b0;
    logic [5:0]        q_addr    = '0;
    logic [Q_W-1:0]    q_data    = '0;
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [COEF_W-1:0] in_data   = '0;
    logic              in_last   = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;
    logic              err;

    izigzag_dequant #(.COEF_W(COEF_W), .Q_W(Q_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .q_load    (q_load),
        .q_addr    (q_addr),
        .q_data    (q_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Standard JPEG zigzag: zigzag index -> raster index.
    int zz [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    int qtab [64];
    int vec  [64];
    int exp_q [$];
    int out_q [$];
    bit last_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int dq(input int v, input int q);
        int p;
        p = v * q;
        if (p > 32767)  return 32767;
        if (p < -32768) return -32768;
        return p;
    endfunction

    // Output monitor: records handshakes and checks hold-while-stalled.
    bit               stall_prev = 1'b0;
    logic [OUT_W-1:0] held_data  = '0;
    logic             held_last  = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && stall_prev) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_data", int'($signed(out_data)), int'($signed(held_data)));
                check("stall_last", int'(out_last), int'(held_last));
            end
            if (rst_n && out_valid && out_ready) begin
                out_q.push_back(int'($signed(out_data)));
                last_q.push_back(out_last);
            end
            stall_prev = rst_n && out_valid && !out_ready;
            held_data  = out_data;
            held_last  = out_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    task automatic apply_reset(input string tag);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        q_load   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_in_ready"},  int'(in_ready), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_last"},  int'(out_last), 0);
        check({tag, "_out_data"},  int'($signed(out_data)), 0);
        check({tag, "_err"},       int'(err), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check({tag, "_ready_after"}, int'(in_ready), 1);
        @(posedge clk); #1;
    endtask

    task automatic load_q(input int addr, input int val);
        q_load = 1'b1;
        q_addr = addr[5:0];
        q_data = val[Q_W-1:0];
        qtab[addr] = val;
        @(posedge clk); #1;
        q_load = 1'b0;
    endtask

    // Presents one coefficient and returns just after its handshake edge.
    task automatic send_coef(input int val, input bit last);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = val[COEF_W-1:0];
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("in_ready_timeout", int'(in_ready), 1);
        @(posedge clk); #1;
    endtask

    task automatic send_vec(input int last_pos);
        for (int k = 0; k < 64; k++) send_coef(vec[k], (k == last_pos));
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_vec();
        int exp_r [64];
        for (int k = 0; k < 64; k++) exp_r[zz[k]] = dq(vec[k], qtab[zz[k]]);
        for (int i = 0; i < 64; i++) exp_q.push_back(exp_r[i]);
    endtask

    task automatic compare_outputs(input string tag, input int n);
        int waited = 0;
        while (out_q.size() < n && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_count"}, out_q.size(), n);
        for (int i = 0; i < n && out_q.size() > 0 && exp_q.size() > 0; i++) begin
            check($sformatf("%s_data[b%0d r%0d]", tag, i / 64, i % 64), out_q.pop_front(), exp_q.pop_front());
            check($sformatf("%s_last[b%0d r%0d]", tag, i / 64, i % 64), int'(last_q.pop_front()), (i % 64 == 63) ? 1 : 0);
        end
        repeat (4) @(negedge clk);
        check({tag, "_no_extra"}, out_q.size(), 0);
        out_q.delete();
        last_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) load_q(i, 1);
        for (int k = 0; k < 64; k++) vec[k] = k;
        expect_vec();
        send_vec(63);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("id_latency_pre%0d", i), int'(out_valid), 0);
        end
        @(negedge clk);
        check("id_latency_3", int'(out_valid), 1);
        check("id_first_data", int'($signed(out_data)), 0);
        @(posedge clk); #1;
        compare_outputs("id", 64);
        check("id_err", int'(err), 0);
    endtask

    task automatic test_saturation();
        load_q(0, 255);
        load_q(1, 0);
        load_q(8, 3);
        load_q(16, 200);
        for (int k = 0; k < 64; k++) vec[k] = k;
        vec[0] = 2047;    // raster 0: 2047*255 -> 32767
        vec[1] = -5;      // raster 1: q=0 -> 0
        vec[2] = -7;      // raster 8: -7*3 = -21
        vec[3] = -300;    // raster 16: -60000 -> -32768
        expect_vec();
        send_vec(63);
        vec[0] = -2048;   // -522240 -> -32768
        vec[1] = 100;     // q=0 -> 0
        vec[2] = 7;       // 21
        vec[3] = 170;     // 34000 -> 32767
        expect_vec();
        send_vec(63);
        compare_outputs("sat", 128);
        check("sat_err", int'(err), 0);
    endtask

    task automatic test_pingpong();
        for (int i = 0; i < 64; i++) load_q(i, (i % 5) + 1);
        out_ready = 1'b0;
        fork
            begin
                for (int b = 0; b < 3; b++) begin
                    for (int k = 0; k < 64; k++) vec[k] = b * 40 - 60 + k;
                    expect_vec();
                    send_vec(63);
                end
            end
            begin
                int seen;
                int cyc;
                seen = 0;
                cyc  = 0;
                while (seen < 128 && cyc < 2000) begin
                    @(negedge clk);
                    if (in_valid && in_ready) seen++;
                    cyc++;
                end
                @(negedge clk);
                check("pp_ready_low", int'(in_ready), 0);
                repeat (8) @(negedge clk);
                check("pp_ready_held", int'(in_ready), 0);
                check("pp_out_waiting", int'(out_valid), 1);
                @(posedge clk); #1;
                out_ready = 1'b1;
                cyc = 0;
                do begin
                    @(negedge clk);
                    cyc++;
                end while (!(out_valid && out_ready && out_last) && cyc < 2000);
                check("pp_first_last_seen", int'(out_valid && out_last), 1);
                check("pp_ready_before_release", int'(in_ready), 0);
                @(negedge clk);
                check("pp_ready_release", int'(in_ready), 1);
            end
        join
        compare_outputs("pp", 192);
    endtask

    task automatic test_stall();
        for (int k = 0; k < 64; k++) vec[k] = 300 - 9 * k;
        expect_vec();
        fork
            send_vec(63);
            begin
                int cyc;
                cyc = 0;
                while (out_q.size() < 64 && cyc < 3000) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                    cyc++;
                end
                out_ready = 1'b1;
            end
        join
        compare_outputs("stall", 64);
    endtask

    task automatic test_framing();
        out_ready = 1'b1;
        for (int k = 0; k < 64; k++) vec[k] = 2 * k - 30;
        expect_vec();
        for (int k = 0; k < 64; k++) begin
            if (k == 10) check("frame_err_before", int'(err), 0);
            send_coef(vec[k], (k == 10));
            if (k == 10) check("frame_err_at_k10", int'(err), 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("frame_err_at_k63", int'(err), 1);
        compare_outputs("frame", 64);
        check("frame_err_sticky", int'(err), 1);
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 30; k++) send_coef(500 + k, 1'b0);
        in_valid = 1'b0;
        apply_reset("mid");
        repeat (10) @(negedge clk);
        check("mid_no_partial_valid", int'(out_valid), 0);
        check("mid_no_partial_out", out_q.size(), 0);
        @(posedge clk); #1;
        for (int k = 0; k < 64; k++) vec[k] = 7 * k - 200;
        expect_vec();
        send_vec(63);
        compare_outputs("mid", 64);
        check("mid_err", int'(err), 0);
    endtask

    initial begin
        apply_reset("rst");
        test_identity();
        test_saturation();
        test_pingpong();
        test_stall();
        test_framing();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
